// File: rtl/mips_muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and a constant-width helper for the iteration counter.
package mips_mdu_pkg;

  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIXUP,
    DONE
  } mdu_state_e;

  // Number of bits needed to encode values 0..value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/mips_muldiv_unit_iter_step.sv
// One iteration of the MDU datapath over the {acc, q} register pair:
// a right-shifting shift-add step for multiply or a restoring step for divide.
module mdu_iter_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] addend;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;

  // Multiply: add multiplicand when q[0] set, then shift {carry, acc, q} right.
  // Divide: shift {acc, q} left, subtract divisor, keep the difference if no borrow.
  always_comb begin
    sum    = {1'b0, acc_i} + {1'b0, b_i};
    addend = q_i[0] ? sum : {1'b0, acc_i};
    rem    = {acc_i, q_i[WIDTH-1]};
    diff   = rem - {1'b0, b_i};
    acc_o  = acc_i;
    q_o    = q_i;
    if (is_div_i) begin
      if (!diff[WIDTH]) begin
        acc_o = diff[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = rem[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = addend[WIDTH:1];
      q_o   = {addend[0], q_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Fixed latency of WIDTH+2 cycles from issue to done for every operation.
// Optional feature macro: MIPS_MDU_DIV_EN enables the divide path; without it
// DIVU/DIV starts are ignored and no divider logic is built.
module mips_muldiv_unit
  import mips_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

`ifdef MIPS_MDU_DIV_EN
  localparam logic DivEn = 1'b1;
`else
  localparam logic DivEn = 1'b0;
`endif

  localparam int unsigned     CntW     = clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             div_q, div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             is_div_op;
  logic             is_signed_op;
  logic             start_ok;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_q;
  logic [2*WIDTH-1:0] prod_neg;
  logic             result_vis;

  assign is_div_op    = (op == MDU_DIVU) || (op == MDU_DIV);
  assign is_signed_op = (op == MDU_MULT) || (op == MDU_DIV);
  assign start_ok     = start && !flush && (DivEn || !is_div_op);
  assign abs_a        = (is_signed_op && src_a[WIDTH-1]) ? -src_a : src_a;
  assign abs_b        = (is_signed_op && src_b[WIDTH-1]) ? -src_b : src_b;
  assign prod_neg     = -{acc_q, q_q};

  mdu_iter_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div_i (DivEn && div_q),
    .acc_i    (acc_q),
    .q_i      (q_q),
    .b_i      (b_q),
    .acc_o    (step_acc),
    .q_o      (step_q)
  );

  // The result sits in {acc, q} during DONE and is committed to HI/LO on the way
  // out, so a flush in DONE can still suppress it without saving old HI/LO.
  assign result_vis = (state_q == DONE) && !flush;
  assign done       = result_vis;
  assign busy       = (state_q == MUL) || (state_q == DIV) || (state_q == FIXUP);
  assign hi         = result_vis ? acc_q : hi_q;
  assign lo         = result_vis ? q_q : lo_q;

  // Next-state, iteration, sign fixup and HI/LO write selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    b_d     = b_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start_ok) begin
          state_d = is_div_op ? DIV : MUL;
          cnt_d   = '0;
          acc_d   = '0;
          q_d     = abs_a;
          b_d     = abs_b;
          div_d   = is_div_op;
          neg_d   = is_signed_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          rneg_d  = is_signed_op && src_a[WIDTH-1];
        end
      end
      MUL, DIV: begin
        acc_d = step_acc;
        q_d   = step_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          state_d = FIXUP;
          cnt_d   = '0;
        end
      end
      FIXUP: begin
        state_d = DONE;
        if (div_q) begin
          acc_d = rneg_q ? -acc_q : acc_q;
          q_d   = (b_q == '0) ? '1 : (neg_q ? -q_q : q_q);
        end else begin
          {acc_d, q_d} = neg_q ? prod_neg : {acc_q, q_q};
        end
      end
      DONE: begin
        state_d = IDLE;
        hi_d    = acc_q;
        lo_d    = q_q;
      end
      default: state_d = IDLE;
    endcase
    if (flush && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State, datapath and architectural register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      b_q     <= b_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit (WIDTH=32). Divide expectations
// follow the MIPS_MDU_DIV_EN build option.
module tb_mips_muldiv_unit;

`ifdef MIPS_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mips_muldiv_unit #(
    .WIDTH(32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural result {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    int sa, sb;
    logic [31:0] qq, rr;
    sa = a;
    sb = b;
    case (o)
      2'd0: return {32'd0, a} * {32'd0, b};
      2'd1: return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        qq = sa / sb;
        rr = sa % sb;
        return {rr, qq};
      end
    endcase
  endfunction

  // Issue one operation (optionally with a same-cycle MTHI/MTLO) and check it.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit we, input logic [31:0] wd);
    logic [63:0] exp;
    logic [31:0] h0, l0;
    int n, bc;
    h0 = hi;
    l0 = lo;
    exp = model(o, a, b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    hi_we = we; lo_we = we; wdata = wd;
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    if (!DIV_EN && o[1]) begin
      chk("ign_busy", 64'(busy), 64'(0));
      tick();
      chk("ign_done", 64'(done), 64'(0));
      chk("ign_hilo", {hi, lo}, {h0, l0});
      return;
    end
    if (we) chk("mt_with_start", {hi, lo}, {wd, wd});
    n = 1;
    bc = 0;
    while (done !== 1'b1 && n < 60) begin
      if (busy === 1'b1) bc++;
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'(34));
    chk("busy_cycles", 64'(bc), 64'(33));
    chk("result_at_done", {hi, lo}, exp);
    chk("busy_in_done", 64'(busy), 64'(0));
    tick();
    chk("done_pulse", 64'(done), 64'(0));
    chk("result_held", {hi, lo}, exp);
  endtask

  logic [31:0] corners [6];
  logic [31:0] ra, rb;
  logic [63:0] first;
  int dones, done_at;

  initial begin
    corners = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7};
    reset = 1'b0; flush = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'd0; src_a = '0; src_b = '0; wdata = '0;
    tick();
    tick();
    chk("reset_state", {62'(busy), done, 1'b0}, 64'(0));
    chk("reset_hilo", {hi, lo}, 64'(0));
    reset = 1'b1;
    tick();

    do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0);
    do_op(2'd1, 32'hFFFF_FFF9, 32'd3, 1'b0, '0);
    do_op(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, '0);
    do_op(2'd2, 32'd100, 32'd0, 1'b0, '0);
    do_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '0);
    do_op(2'd3, 32'hFFFF_FFF0, 32'd0, 1'b0, '0);

    // Reset, MTHI, then flush an in-flight MULT at cycle 10.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    hi_we = 1'b1; wdata = 32'h1234;
    tick();
    hi_we = 1'b0;
    chk("mthi", {hi, lo}, {32'h1234, 32'h0});
    op = 2'd1; src_a = 32'd6; src_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_hilo", {hi, lo}, {32'h1234, 32'h0});
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    chk("flush_no_done", 64'(dones), 64'(0));
    do_op(2'd1, 32'd6, 32'd7, 1'b0, '0);

    // Flush in IDLE drops a same-cycle start.
    op = 2'd0; src_a = 32'd9; src_b = 32'd9; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_drop", 64'(busy), 64'(0));

    // Starts every cycle while busy and in DONE are ignored.
    first = model(2'd0, 32'd1000, 32'd3000);
    op = 2'd0; src_a = 32'd1000; src_b = 32'd3000; start = 1'b1;
    tick();
    dones = 0;
    done_at = 0;
    for (int n = 1; n <= 34; n++) begin
      if (done === 1'b1) begin
        dones++;
        done_at = n;
        chk("ignore_result", {hi, lo}, first);
      end
      op = 2'($urandom_range(0, 3)); src_a = $urandom; src_b = $urandom; start = 1'b1;
      tick();
    end
    start = 1'b0;
    chk("ignore_single_done", 64'(dones), 64'(1));
    chk("ignore_done_at", 64'(done_at), 64'(34));
    chk("ignore_idle_after", {62'(busy), done, 1'b0}, 64'(0));
    chk("ignore_hilo_kept", {hi, lo}, first);

    // Reset in the middle of an operation.
    op = 2'd0; src_a = 32'd5; src_b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midreset_state", {62'(busy), done, 1'b0}, 64'(0));
    chk("midreset_hilo", {hi, lo}, 64'(0));
    tick();
    chk("midreset_no_done", 64'(done), 64'(0));

    do_op(2'd2, 32'd100, 32'd0, 1'b0, '0);
    do_op(2'd0, 32'd3, 32'd5, 1'b1, 32'hCAFE_F00D);

    // Randomised operations with occasional corner operands.
    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
      do_op(2'($urandom_range(0, 3)), ra, rb, 1'b0, '0);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
